// File: rtl/id_operand_fetch.sv
// id_operand_fetch: decode / operand-fetch stage of the 5-stage MIPS-subset pipeline.
// Decodes the IF/ID word, drives the regfile read ports, forwards from EX/MEM,
// raises a load-use stall request and registers the result into ID/EX.
// Optional macro ID_STALL_CNT_EN adds a free-running load-use stall counter (stall_cnt_o).
module id_operand_fetch #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   inst_i,
   input  logic          inst_valid_i,
   output logic          re1,
   output logic [RW-1:0] raddr1,
   output logic          re2,
   output logic [RW-1:0] raddr2,
   input  logic [DW-1:0] rdata1,
   input  logic [DW-1:0] rdata2,
   input  logic          ex_we_i,
   input  logic [RW-1:0] ex_waddr_i,
   input  logic [DW-1:0] ex_wdata_i,
   input  logic          ex_is_load_i,
   input  logic          mem_we_i,
   input  logic [RW-1:0] mem_waddr_i,
   input  logic [DW-1:0] mem_wdata_i,
   input  logic          stall_i,
   input  logic          flush_i,
   output logic          stall_req_o,
   output logic          ex_valid_o,
   output logic [5:0]    ex_opcode_o,
   output logic [5:0]    ex_funct_o,
   output logic [DW-1:0] ex_op1_o,
   output logic [DW-1:0] ex_op2_o,
   output logic [DW-1:0] ex_sdata_o,
   output logic          ex_we_o,
   output logic [RW-1:0] ex_waddr_o,
   output logic          ex_is_load_o,
   output logic          ex_illegal_o
`ifdef ID_STALL_CNT_EN
   ,
   output logic [31:0]   stall_cnt_o
`endif
);

   // ID/EX pipeline register contents
   typedef struct packed {
      logic          valid;
      logic [5:0]    opcode;
      logic [5:0]    funct;
      logic [DW-1:0] op1;
      logic [DW-1:0] op2;
      logic [DW-1:0] sdata;
      logic          we;
      logic [RW-1:0] waddr;
      logic          is_load;
      logic          illegal;
   } idex_t;

   logic [5:0]    opcode;
   logic [RW-1:0] rs, rt, rd;
   logic [15:0]   imm;
   logic [DW-1:0] sext, zext, luiv;

   logic          use_imm, is_store, dec_we;
   logic [DW-1:0] imm_val, src1, src2;
   idex_t         d, q;
   logic          load_use;

   assign opcode = inst_i[31:26];
   assign rs     = inst_i[25:21];
   assign rt     = inst_i[20:16];
   assign rd     = inst_i[15:11];
   assign imm    = inst_i[15:0];
   assign sext   = {{(DW-16){imm[15]}}, imm};
   assign zext   = {{(DW-16){1'b0}}, imm};
   assign luiv   = {imm, {(DW-16){1'b0}}};

   assign raddr1 = rs;
   assign raddr2 = rt;

   // Instruction class decode; an invalid slot decodes to an all-zero bubble
   always_comb begin
      re1       = 1'b0;
      re2       = 1'b0;
      use_imm   = 1'b0;
      is_store  = 1'b0;
      imm_val   = '0;
      dec_we    = 1'b0;
      d         = '0;
      if (inst_valid_i) begin
         d.valid  = 1'b1;
         d.opcode = opcode;
         unique case (opcode)
            6'b000000: begin
               re1     = 1'b1;
               re2     = 1'b1;
               d.funct = inst_i[5:0];
               dec_we  = 1'b1;
               d.waddr = rd;
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011: begin
               re1     = 1'b1;
               use_imm = 1'b1;
               imm_val = sext;
               dec_we  = 1'b1;
               d.waddr = rt;
            end
            6'b001100, 6'b001101, 6'b001110: begin
               re1     = 1'b1;
               use_imm = 1'b1;
               imm_val = zext;
               dec_we  = 1'b1;
               d.waddr = rt;
            end
            6'b001111: begin
               use_imm = 1'b1;
               imm_val = luiv;
               dec_we  = 1'b1;
               d.waddr = rt;
            end
            6'b100011: begin
               re1       = 1'b1;
               use_imm   = 1'b1;
               imm_val   = sext;
               dec_we    = 1'b1;
               d.waddr   = rt;
               d.is_load = 1'b1;
            end
            6'b101011: begin
               re1      = 1'b1;
               re2      = 1'b1;
               use_imm  = 1'b1;
               imm_val  = sext;
               is_store = 1'b1;
            end
            default: d.illegal = 1'b1;
         endcase
         // r0 is never a real destination
         d.we = dec_we && (d.waddr != '0);
         d.op1   = re1 ? src1 : '0;
         d.op2   = use_imm ? imm_val : (re2 ? src2 : '0);
         d.sdata = is_store ? src2 : '0;
      end
   end

   // Operand resolution: r0, then youngest producer (EX), then MEM, then regfile
   always_comb begin
      if (rs == '0)                           src1 = '0;
      else if (ex_we_i && ex_waddr_i == rs)   src1 = ex_wdata_i;
      else if (mem_we_i && mem_waddr_i == rs) src1 = mem_wdata_i;
      else                                    src1 = rdata1;
      if (rt == '0)                           src2 = '0;
      else if (ex_we_i && ex_waddr_i == rt)   src2 = ex_wdata_i;
      else if (mem_we_i && mem_waddr_i == rt) src2 = mem_wdata_i;
      else                                    src2 = rdata2;
   end

   // Load in EX whose result is needed now: the EX forward would carry an address, not data
   assign load_use = inst_valid_i && ex_is_load_i && ex_we_i && (ex_waddr_i != '0) &&
                     ((re1 && ex_waddr_i == rs) || (re2 && ex_waddr_i == rt));
   assign stall_req_o = load_use && rst;

   // ID/EX register: flush beats hold, hold beats the load-use bubble
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)             q <= '0;
      else if (flush_i)     q <= '0;
      else if (stall_i)     q <= q;
      else if (stall_req_o) q <= '0;
      else                  q <= d;
   end

   assign ex_valid_o   = q.valid;
   assign ex_opcode_o  = q.opcode;
   assign ex_funct_o   = q.funct;
   assign ex_op1_o     = q.op1;
   assign ex_op2_o     = q.op2;
   assign ex_sdata_o   = q.sdata;
   assign ex_we_o      = q.we;
   assign ex_waddr_o   = q.waddr;
   assign ex_is_load_o = q.is_load;
   assign ex_illegal_o = q.illegal;

`ifdef ID_STALL_CNT_EN
   // Counts bubbles actually inserted for load-use; a flush leaves it alone
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                         stall_cnt_o <= '0;
      else if (stall_req_o && !stall_i) stall_cnt_o <= stall_cnt_o + 32'd1;
   end
`endif

endmodule

// File: tb/tb_id_operand_fetch.sv
// Bench for id_operand_fetch: directed test-plan steps followed by random traffic,
// checked against a behavioural decode/forwarding model.
module tb_id_operand_fetch;

   typedef struct packed {
      logic        valid;
      logic [5:0]  opc;
      logic [5:0]  fn;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] sd;
      logic        we;
      logic [4:0]  wa;
      logic        ld;
      logic        ill;
   } idex_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst_i;
   logic        inst_valid_i;
   logic        re1, re2;
   logic [4:0]  raddr1, raddr2;
   logic [31:0] rdata1, rdata2;
   logic        ex_we_i, ex_is_load_i, mem_we_i, stall_i, flush_i;
   logic [4:0]  ex_waddr_i, mem_waddr_i;
   logic [31:0] ex_wdata_i, mem_wdata_i;
   logic        stall_req_o, ex_valid_o, ex_we_o, ex_is_load_o, ex_illegal_o;
   logic [5:0]  ex_opcode_o, ex_funct_o;
   logic [31:0] ex_op1_o, ex_op2_o, ex_sdata_o;
   logic [4:0]  ex_waddr_o;
`ifdef ID_STALL_CNT_EN
   logic [31:0] stall_cnt_o;
`endif

   logic [31:0] rf [32];
   int          checks = 0;
   int          errors = 0;
   idex_t       exp_q, exp_m, full_m, part_m;
   logic [31:0] exp_cnt;

   always #5 clk = ~clk;

   assign rdata1 = rf[raddr1];
   assign rdata2 = rf[raddr2];

   id_operand_fetch #(.DW(32), .RW(5)) dut (
      .clk(clk), .rst(rst), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
      .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
      .rdata1(rdata1), .rdata2(rdata2),
      .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
      .ex_is_load_i(ex_is_load_i),
      .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
      .stall_i(stall_i), .flush_i(flush_i), .stall_req_o(stall_req_o),
      .ex_valid_o(ex_valid_o), .ex_opcode_o(ex_opcode_o), .ex_funct_o(ex_funct_o),
      .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o), .ex_sdata_o(ex_sdata_o),
      .ex_we_o(ex_we_o), .ex_waddr_o(ex_waddr_o), .ex_is_load_o(ex_is_load_o),
      .ex_illegal_o(ex_illegal_o)
`ifdef ID_STALL_CNT_EN
      , .stall_cnt_o(stall_cnt_o)
`endif
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic idex_t dut_obs();
      return {ex_valid_o, ex_opcode_o, ex_funct_o, ex_op1_o, ex_op2_o, ex_sdata_o,
              ex_we_o, ex_waddr_o, ex_is_load_o, ex_illegal_o};
   endfunction

   // Value a source register should have right now
   function automatic logic [31:0] src(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (ex_we_i && ex_waddr_i == a) return ex_wdata_i;
      if (mem_we_i && mem_waddr_i == a) return mem_wdata_i;
      return rf[a];
   endfunction

   // Architectural meaning of the current instruction word
   function automatic idex_t ref_dec(output bit r1, output bit r2);
      idex_t       d;
      int          o;
      logic [15:0] imm;
      logic [31:0] simm, zimm;
      d  = '0;
      r1 = 1'b0;
      r2 = 1'b0;
      if (!inst_valid_i) return d;
      o    = int'(inst_i[31:26]);
      imm  = inst_i[15:0];
      simm = 32'($signed(imm));
      zimm = 32'(imm);
      d.valid = 1'b1;
      d.opc   = inst_i[31:26];
      if (o == 0) begin
         r1 = 1; r2 = 1;
         d.fn  = inst_i[5:0];
         d.op1 = src(inst_i[25:21]);
         d.op2 = src(inst_i[20:16]);
         d.wa  = inst_i[15:11];
         d.we  = 1'b1;
      end else if (o >= 8 && o <= 14) begin
         r1 = 1;
         d.op1 = src(inst_i[25:21]);
         d.op2 = (o <= 11) ? simm : zimm;
         d.wa  = inst_i[20:16];
         d.we  = 1'b1;
      end else if (o == 15) begin
         d.op2 = zimm << 16;
         d.wa  = inst_i[20:16];
         d.we  = 1'b1;
      end else if (o == 35) begin
         r1 = 1;
         d.op1 = src(inst_i[25:21]);
         d.op2 = simm;
         d.wa  = inst_i[20:16];
         d.we  = 1'b1;
         d.ld  = 1'b1;
      end else if (o == 43) begin
         r1 = 1; r2 = 1;
         d.op1 = src(inst_i[25:21]);
         d.op2 = simm;
         d.sd  = src(inst_i[20:16]);
      end else begin
         d.ill = 1'b1;
      end
      if (d.wa == 5'd0) d.we = 1'b0;
      return d;
   endfunction

   // One clock: check combinational outputs mid-cycle, then the registered result
   task automatic cycle();
      idex_t d;
      bit    r1, r2, sr;
      d  = ref_dec(r1, r2);
      sr = rst && inst_valid_i && ex_is_load_i && ex_we_i && ex_waddr_i != 5'd0 &&
           ((r1 && ex_waddr_i == inst_i[25:21]) || (r2 && ex_waddr_i == inst_i[20:16]));
      @(negedge clk);
      check("comb", 128'({re1, re1 ? raddr1 : 5'd0, re2, re2 ? raddr2 : 5'd0, stall_req_o}),
                    128'({r1, r1 ? inst_i[25:21] : 5'd0, r2, r2 ? inst_i[20:16] : 5'd0, sr}));
      @(posedge clk);
      if (flush_i) begin
         exp_q = '0; exp_m = full_m;
      end else if (!stall_i) begin
         if (sr) begin
            exp_q = '0; exp_m = full_m;
         end else begin
            exp_q = d; exp_m = inst_valid_i ? full_m : part_m;
         end
      end
      if (sr && !stall_i) exp_cnt = exp_cnt + 32'd1;
      #1;
      check("idex", 128'(dut_obs() & exp_m), 128'(exp_q & exp_m));
`ifdef ID_STALL_CNT_EN
      check("stall_cnt", 128'(stall_cnt_o), 128'(exp_cnt));
`endif
   endtask

   task automatic clr_fwd();
      ex_we_i = 0; ex_waddr_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
      mem_we_i = 0; mem_waddr_i = 0; mem_wdata_i = 0;
      stall_i = 0; flush_i = 0;
   endtask

   initial begin
      full_m = '1;
      part_m = '0; part_m.valid = 1'b1; part_m.we = 1'b1; part_m.ld = 1'b1;
      exp_q = '0; exp_m = full_m; exp_cnt = '0;
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rf[0] = 32'hDEAD_BEEF;   // must never be seen as an operand
      rf[1] = 32'd5;

      // Reset held with a live load-use condition on the inputs
      rst = 1'b0;
      clr_fwd();
      inst_i = 32'h0022_1820; inst_valid_i = 1'b1;     // add r3,r1,r2
      ex_we_i = 1; ex_is_load_i = 1; ex_waddr_i = 5'd2;
      repeat (2) @(posedge clk);
      #1;
      check("rst_idex", 128'(dut_obs()), 128'(0));
      check("rst_stall_req", 128'(stall_req_o), 128'(0));
      rst = 1'b1;
      clr_fwd();

      // addi r2,r1,-1
      inst_i = 32'h2022_FFFF;
      cycle();
      check("addi", 128'({ex_op1_o, ex_op2_o, ex_waddr_o, ex_we_o, ex_valid_o}),
                    128'({32'd5, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b1}));

      // add r3,r1,r2: EX forward beats MEM forward
      inst_i = 32'h0022_1820;
      ex_we_i = 1; ex_waddr_i = 5'd1; ex_wdata_i = 32'hAA;
      mem_we_i = 1; mem_waddr_i = 5'd1; mem_wdata_i = 32'hBB;
      cycle();
      check("fwd_ex_prio", 128'({ex_op1_o, ex_funct_o, ex_waddr_o}), 128'({32'hAA, 6'h20, 5'd3}));

      // Same add behind a load to r2: one bubble, then MEM forward
      ex_is_load_i = 1; ex_waddr_i = 5'd2;
      cycle();
      check("load_use_bubble", 128'({ex_valid_o, ex_we_o}), 128'(0));
      ex_we_i = 0; ex_is_load_i = 0;
      mem_we_i = 1; mem_waddr_i = 5'd2; mem_wdata_i = 32'h77;
      cycle();
      check("load_use_mem", 128'({ex_op2_o, ex_valid_o}), 128'({32'h77, 1'b1}));
      clr_fwd();

      // ori r0,r1,3: no write to r0
      inst_i = 32'h3420_0003;
      cycle();
      check("ori_r0", 128'({ex_we_o, ex_op2_o}), 128'({1'b0, 32'd3}));

      // Unknown opcode
      inst_i = 32'hFC22_1820;
      cycle();
      check("illegal", 128'({ex_illegal_o, ex_we_o}), 128'({1'b1, 1'b0}));

      // r0 source reads zero even with an EX write aimed at r0; lui
      inst_i = 32'h0001_2020;                           // add r4,r0,r1
      ex_we_i = 1; ex_waddr_i = 5'd0; ex_wdata_i = 32'h123;
      cycle();
      check("r0_src", 128'({ex_op1_o, ex_op2_o}), 128'({32'd0, 32'd5}));
      clr_fwd();
      inst_i = 32'h3C05_8001;                           // lui r5,0x8001
      cycle();
      check("lui", 128'({ex_op1_o, ex_op2_o, ex_waddr_o}), 128'({32'd0, 32'h8001_0000, 5'd5}));

      // Flush with stall: flush wins
      inst_i = 32'h2022_FFFF;
      stall_i = 1; flush_i = 1;
      cycle();
      check("flush_wins", 128'(ex_valid_o), 128'(0));
      clr_fwd();

      // Load a valid op, then hold for 3 cycles with different inputs
      cycle();
      inst_i = 32'h8C23_0010;                           // lw r3,16(r1)
      stall_i = 1;
      repeat (3) cycle();
      check("hold_addi", 128'({ex_valid_o, ex_op2_o, ex_waddr_o}), 128'({1'b1, 32'hFFFF_FFFF, 5'd2}));
      // Hold coinciding with load-use: register held, request still raised
      ex_we_i = 1; ex_is_load_i = 1; ex_waddr_i = 5'd1;
      cycle();
      clr_fwd();
      cycle();

      // Asynchronous reset between edges with a valid op in ID/EX
      check("pre_rst_valid", 128'(ex_valid_o), 128'(1));
      ex_we_i = 1; ex_is_load_i = 1; ex_waddr_i = 5'd1;
      #2 rst = 1'b0;
      #1;
      check("async_rst_idex", 128'(dut_obs()), 128'(0));
      check("async_rst_stall_req", 128'(stall_req_o), 128'(0));
      exp_q = '0; exp_m = full_m; exp_cnt = '0;
      @(posedge clk);
      #1 rst = 1'b1;
      clr_fwd();

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         logic [5:0] opc;
         case ($urandom_range(0, 8))
            0, 7:    opc = 6'd0;
            1:       opc = 6'(8 + $urandom_range(0, 3));
            2:       opc = 6'(12 + $urandom_range(0, 2));
            3:       opc = 6'd15;
            4, 8:    opc = 6'd35;
            5:       opc = 6'd43;
            default: opc = 6'($urandom_range(0, 63));
         endcase
         inst_i = {opc, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
         if ($urandom_range(0, 1) == 1) inst_i[15:11] = 5'($urandom_range(0, 7));
         inst_valid_i = ($urandom_range(0, 9) != 0);
         ex_we_i      = $urandom_range(0, 1) == 1;
         ex_waddr_i   = 5'($urandom_range(0, 7));
         ex_wdata_i   = $urandom;
         ex_is_load_i = $urandom_range(0, 2) == 0;
         mem_we_i     = $urandom_range(0, 1) == 1;
         mem_waddr_i  = 5'($urandom_range(0, 7));
         mem_wdata_i  = $urandom;
         stall_i      = $urandom_range(0, 6) == 0;
         flush_i      = $urandom_range(0, 9) == 0;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
